// File: rtl/board_key_event.sv
// Board key event unit: per-key debounce on a shared sample tick, press/release
// edge capture, and a small event FIFO popped by the CPU.
module board_key_event #(
   parameter int DATA_WIDTH      = 8,
   parameter int KEY_WIDTH       = 6,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int FIFO_DEPTH_BITS = 3
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [KEY_WIDTH-1:0]         key_in,
   input  logic                         read_req,
   input  logic                         clear_overflow,
   output logic signed [DATA_WIDTH-1:0] data,
   output logic                         event_valid,
   output logic                         overflow,
   output logic [KEY_WIDTH-1:0]         level
);

   localparam int IDX_W = (KEY_WIDTH > 1) ? $clog2(KEY_WIDTH) : 1;
   localparam int PRE_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
   localparam int CNT_W = FIFO_DEPTH_BITS + 1;

   logic [PRE_W-1:0]     prescale;
   logic                 tick;
   logic [KEY_WIDTH-1:0] hist0, hist1;
   logic [KEY_WIDTH-1:0] agree, change, rise, fall;
   logic [KEY_WIDTH-1:0] press_pend, rel_pend;
   logic [KEY_WIDTH-1:0] press_clr, rel_clr;

   logic                 push, push_rel;
   logic [IDX_W-1:0]     push_idx;
   logic [DATA_WIDTH-1:0] ev_code;

   logic [DATA_WIDTH-1:0]      mem [DEPTH];
   logic [FIFO_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0]           count;
   logic                       empty, full, pop, wr_en, drop;

   assign tick = (prescale == PRE_W'(DEBOUNCE_CYCLES - 1));

   // A key flips only when the new sample and both history samples agree.
   assign agree  = ~(key_in ^ hist0) & ~(key_in ^ hist1);
   assign change = agree & (key_in ^ level);
   assign rise   = change & key_in;
   assign fall   = change & ~key_in;

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      push     = 1'b0;
      push_rel = 1'b0;
      push_idx = '0;
      // Scan from the top down so the lowest index wins; presses overwrite releases.
      for (int i = KEY_WIDTH - 1; i >= 0; i--) begin
         if (rel_pend[i]) begin
            push     = 1'b1;
            push_rel = 1'b1;
            push_idx = IDX_W'(i);
         end
      end
      for (int i = KEY_WIDTH - 1; i >= 0; i--) begin
         if (press_pend[i]) begin
            push     = 1'b1;
            push_rel = 1'b0;
            push_idx = IDX_W'(i);
         end
      end
   end

   assign press_clr = (push && !push_rel) ? (KEY_WIDTH'(1) << push_idx) : '0;
   assign rel_clr   = (push &&  push_rel) ? (KEY_WIDTH'(1) << push_idx) : '0;

   always_comb begin
      ev_code                 = '0;
      ev_code[DATA_WIDTH-1]   = push_rel;
      ev_code[IDX_W-1:0]      = push_idx;
   end

   assign empty = (count == '0);
   assign full  = (count == CNT_W'(DEPTH));
   assign pop   = read_req && !empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign wr_en = push && (!full || pop);
   assign drop  = push && full && !pop;

   // NOTE: sequential state is updated only with non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         prescale    <= '0;
         hist0       <= '0;
         hist1       <= '0;
         level       <= '0;
         press_pend  <= '0;
         rel_pend    <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         data        <= '0;
         event_valid <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         prescale <= tick ? '0 : prescale + 1'b1;

         if (tick) begin
            hist0 <= key_in;
            hist1 <= hist0;
            level <= level ^ change;
         end

         press_pend <= (press_pend & ~press_clr) | (tick ? rise : '0);
         rel_pend   <= (rel_pend   & ~rel_clr)   | (tick ? fall : '0);

         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         // Head is presented one cycle after the FIFO state it reflects.
         event_valid <= !empty;
         data        <= empty ? '0 : $signed(mem[rd_ptr]);

         if (drop)                overflow <= 1'b1;
         else if (clear_overflow) overflow <= 1'b0;
      end
   end

   // NOTE: the storage array carries no reset; the pointers and count alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= ev_code;
   end

endmodule

// File: tb/tb_board_key_event.sv
// Bench for board_key_event: directed scenarios plus random stimulus, all
// compared every cycle against a tick/queue level reference model.
module tb_board_key_event;

   localparam int KW    = 6;
   localparam int DW    = 8;
   localparam int DC    = 16;
   localparam int FDB   = 2;
   localparam int DEPTH = 1 << FDB;

   logic                 clk;
   logic                 reset;
   logic [KW-1:0]        key_in;
   logic                 read_req;
   logic                 clear_overflow;
   logic signed [DW-1:0] data;
   logic                 event_valid;
   logic                 overflow;
   logic [KW-1:0]        level;

   int n_checks = 0;
   int n_fail   = 0;

   board_key_event #(
      .DATA_WIDTH(DW), .KEY_WIDTH(KW), .DEBOUNCE_CYCLES(DC), .FIFO_DEPTH_BITS(FDB)
   ) dut (
      .clk(clk), .reset(reset), .key_in(key_in), .read_req(read_req),
      .clear_overflow(clear_overflow), .data(data), .event_valid(event_valid),
      .overflow(overflow), .level(level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   int         m_pre;
   bit         m_last [KW];
   int         m_run  [KW];
   logic [KW-1:0] m_level;
   bit         m_press [KW];
   bit         m_rel   [KW];
   logic [7:0] m_q [$];
   logic       m_valid, m_ovf;
   logic [7:0] m_data;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pre = 0;
      for (int i = 0; i < KW; i++) begin
         m_last[i]  = 1'b0;
         m_run[i]   = 2;   // reset history counts as two zero samples
         m_press[i] = 1'b0;
         m_rel[i]   = 1'b0;
      end
      m_level = '0;
      m_q.delete();
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_ovf   = 1'b0;
   endtask

   task automatic model_step();
      logic       nv;
      logic [7:0] nd, ev;
      bit         have, drop, s;
      if (reset) begin
         model_reset();
         return;
      end
      nv = (m_q.size() != 0);
      nd = nv ? m_q[0] : 8'h00;
      have = 1'b0;
      ev   = 8'h00;
      for (int i = 0; i < KW; i++)
         if (!have && m_press[i]) begin have = 1'b1; ev = 8'(i); m_press[i] = 1'b0; end
      for (int i = 0; i < KW; i++)
         if (!have && m_rel[i]) begin have = 1'b1; ev = 8'h80 | 8'(i); m_rel[i] = 1'b0; end
      if (read_req && m_q.size() != 0) void'(m_q.pop_front());
      drop = 1'b0;
      if (have) begin
         if (m_q.size() < DEPTH) m_q.push_back(ev);
         else drop = 1'b1;
      end
      if (drop) m_ovf = 1'b1;
      else if (clear_overflow) m_ovf = 1'b0;
      if (m_pre == DC - 1) begin
         for (int i = 0; i < KW; i++) begin
            s = key_in[i];
            if (s == m_last[i]) m_run[i] = (m_run[i] < 3) ? m_run[i] + 1 : 3;
            else begin m_last[i] = s; m_run[i] = 1; end
            if (m_run[i] >= 3 && s != m_level[i]) begin
               m_level[i] = s;
               if (s) m_press[i] = 1'b1;
               else   m_rel[i]   = 1'b1;
            end
         end
         m_pre = 0;
      end else begin
         m_pre++;
      end
      m_valid = nv;
      m_data  = nd;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check("level", level, m_level);
      check("event_valid", event_valid, m_valid);
      check("data", $unsigned(data), m_data);
      check("overflow", overflow, m_ovf);
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic pop_one();
      read_req = 1'b1;
      cycle();
      read_req = 1'b0;
      cycle();
   endtask

   task automatic drain();
      for (int k = 0; k < 3 * DEPTH; k++) begin
         if (!event_valid) break;
         pop_one();
      end
      check("drain_empty", event_valid, 1'b0);
   endtask

   task automatic clear_ovf();
      clear_overflow = 1'b1;
      cycle();
      clear_overflow = 1'b0;
      cycle();
   endtask

   task automatic wait_valid(input string tag);
      for (int k = 0; k < 200; k++) begin
         if (event_valid) break;
         cycle();
      end
      check(tag, event_valid, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int n;
      logic [7:0] exp_seq [4];
      reset = 1'b1; key_in = '0; read_req = 1'b0; clear_overflow = 1'b0;
      model_reset();

      // Reset and idle
      run(2);
      reset = 1'b0;
      run(200);
      check("t1_level", level, 6'h00);
      check("t1_valid", event_valid, 1'b0);
      check("t1_data", $unsigned(data), 8'h00);
      check("t1_ovf", overflow, 1'b0);

      // Press key 3, measure latency, pop, release
      key_in[3] = 1'b1;
      for (int k = 0; k < 100; k++) begin
         if (level[3]) break;
         cycle();
      end
      check("t2_level_rise", level[3], 1'b1);
      n = 0;
      for (int k = 0; k < 10; k++) begin
         if (event_valid) break;
         cycle();
         n++;
      end
      check("t2_latency", n, 2);
      check("t2_press_code", $unsigned(data), 8'h03);
      pop_one();
      check("t2_pop_valid", event_valid, 1'b0);
      check("t2_pop_data", $unsigned(data), 8'h00);
      key_in[3] = 1'b0;
      wait_valid("t2_rel_seen");
      check("t2_rel_code", $unsigned(data), 8'h83);
      pop_one();

      // Key 1 glitch seen by exactly one tick
      for (int k = 0; k < 2 * DC; k++) begin
         if (m_pre == 0) break;
         cycle();
      end
      key_in[1] = 1'b1;
      run(DC);
      key_in[1] = 1'b0;
      run(60);
      check("t3_level", level[1], 1'b0);
      check("t3_valid", event_valid, 1'b0);

      // Keys 5 and 0 together
      key_in = 6'b100001;
      wait_valid("t4_seen");
      check("t4_first", $unsigned(data), 8'h00);
      pop_one();
      check("t4_second_valid", event_valid, 1'b1);
      check("t4_second", $unsigned(data), 8'h05);
      pop_one();
      check("t4_empty", event_valid, 1'b0);
      key_in = '0;
      run(100);
      drain();

      // Six presses into a four-deep FIFO
      key_in = 6'h3f;
      run(100);
      check("t5_ovf", overflow, 1'b1);
      for (int k = 0; k < 4; k++) begin
         check("t5_pop_valid", event_valid, 1'b1);
         check("t5_pop_code", $unsigned(data), 32'(k));
         pop_one();
      end
      check("t5_empty", event_valid, 1'b0);
      clear_ovf();
      check("t5_ovf_clr", overflow, 1'b0);
      key_in = '0;
      run(100);
      drain();
      clear_ovf();

      // Full FIFO with a pop in the push cycle
      key_in = 6'h1f;
      for (int k = 0; k < 200; k++) begin
         if (m_q.size() == DEPTH) break;
         cycle();
      end
      read_req = 1'b1;
      cycle();
      read_req = 1'b0;
      run(3);
      check("t6_no_ovf", overflow, 1'b0);
      exp_seq = '{8'h01, 8'h02, 8'h03, 8'h04};
      for (int k = 0; k < 4; k++) begin
         check("t6_code", $unsigned(data), exp_seq[k]);
         pop_one();
      end
      check("t6_empty", event_valid, 1'b0);

      // Reset while events are queued
      key_in = '0;
      for (int k = 0; k < 200; k++) begin
         if (m_q.size() >= 2) break;
         cycle();
      end
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      check("t6_rst_valid", event_valid, 1'b0);
      check("t6_rst_data", $unsigned(data), 8'h00);
      check("t6_rst_ovf", overflow, 1'b0);
      check("t6_rst_level", level, 6'h00);
      run(50);

      // Random phase
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 19) == 0) key_in = KW'($urandom);
         read_req       = ($urandom_range(0, 3) == 0);
         clear_overflow = ($urandom_range(0, 19) == 0);
         reset          = ($urandom_range(0, 999) == 0);
         cycle();
      end
      reset = 1'b0; read_req = 1'b0; clear_overflow = 1'b0;
      run(5);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
